// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator ALU and its operation sequencer:
// function codes, the no-op encoding, the op record and the sequencer states.
package alu_pkg;

   localparam logic [2:0] FN_ADD     = 3'b000;
   localparam logic [2:0] FN_OR_ANY  = 3'b001;
   localparam logic [2:0] FN_AND_ALL = 3'b010;
   localparam logic [2:0] FN_CONCAT  = 3'b011;

   // ADD of zero reloads {4'b0000, B}: keeps the accumulator low nibble.
   localparam logic [2:0] NOP_FUNC = FN_ADD;
   localparam logic [3:0] NOP_DATA = 4'h0;

   typedef struct packed {
      logic [2:0] func;
      logic [3:0] data;
   } op_t;

   localparam op_t NOP_OP = '{func: NOP_FUNC, data: NOP_DATA};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESULT  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/op_fifo.sv
// Synchronous op FIFO with count-based full/empty flags; DEPTH is a power of two.
// Pushes while full and pops while empty are dropped inside the FIFO.
module op_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic Clock,
   input  logic Reset_b,
   input  logic push,
   input  op_t  push_op,
   input  logic pop,
   output op_t  head,
   output logic full,
   output logic empty
);

   localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   op_t           mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage is not reset; only the pointers and count define validity.
   always_ff @(posedge Clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_op;
      end
   end

   always_ff @(posedge Clock or negedge Reset_b) begin
      if (!Reset_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator for the accumulator ALU: queues ops, issues one at a time with a
// no-op between them, and returns each registered result over valid/ready.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             Clock,
   input  logic             Reset_b,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       op_func,
   input  logic [3:0]       op_data,
   output logic [3:0]       alu_data,
   output logic [2:0]       alu_func,
   input  logic [7:0]       alu_result,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [7:0]       res_data,
   output logic [CNT_W-1:0] ops_issued,
   output seq_state_t       seq_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // A source holds valid and its payload stable until that transfer; ready
   // never depends combinationally on the other side's valid.

   seq_state_t       state_q, state_d;
   op_t              alu_op_q, alu_op_d;
   logic             res_valid_q, res_valid_d;
   logic [7:0]       res_data_q, res_data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   op_t  fifo_head;
   logic fifo_full;
   logic fifo_empty;
   logic pop;

   op_fifo #(.DEPTH(DEPTH)) u_op_fifo (
      .Clock   (Clock),
      .Reset_b (Reset_b),
      .push    (op_valid),
      .push_op ('{func: op_func, data: op_data}),
      .pop     (pop),
      .head    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      alu_op_d    = alu_op_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      cnt_d       = cnt_q;
      pop         = 1'b0;
      case (state_q)
         IDLE: begin
            alu_op_d = NOP_OP;
            if (!fifo_empty) begin
               pop      = 1'b1;
               alu_op_d = fifo_head;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            alu_op_d = NOP_OP;
            cnt_d    = cnt_q + 1'b1;
            state_d  = CAPTURE;
         end
         // The accumulator holds the op's result now; the no-op lands after.
         CAPTURE: begin
            res_data_d  = alu_result;
            res_valid_d = 1'b1;
            state_d     = RESULT;
         end
         RESULT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            alu_op_d = NOP_OP;
            state_d  = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_b) begin
      if (!Reset_b) begin
         state_q     <= IDLE;
         alu_op_q    <= NOP_OP;
         res_valid_q <= 1'b0;
         res_data_q  <= 8'h00;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         alu_op_q    <= alu_op_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         cnt_q       <= cnt_d;
      end
   end

   assign op_ready   = !fifo_full;
   assign alu_data   = alu_op_q.data;
   assign alu_func   = alu_op_q.func;
   assign res_valid  = res_valid_q;
   assign res_data   = res_data_q;
   assign ops_issued = cnt_q;
   assign seq_state  = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: the sequencer driving a behavioural accumulator ALU, with
// hand-computed results checked in order through an expected queue.
module tb_alu_op_sequencer;
   import alu_pkg::*;

   localparam int DEPTH  = 8;
   localparam int CNT_W  = 8;
   localparam int BUDGET = 3000;

   logic             Clock = 1'b0;
   logic             Reset_b;
   logic             op_valid;
   logic             op_ready;
   logic [2:0]       op_func;
   logic [3:0]       op_data;
   logic [3:0]       alu_data;
   logic [2:0]       alu_func;
   logic [7:0]       acc;
   logic             res_valid;
   logic             res_ready;
   logic [7:0]       res_data;
   logic [CNT_W-1:0] ops_issued;
   seq_state_t       seq_state;

   logic [7:0] exp_q[$];
   int         n_checks = 0;
   int         n_errors = 0;

   // ---------------- clock / reset ----------------
   always #5 Clock = ~Clock;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   alu_op_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .Clock      (Clock),
      .Reset_b    (Reset_b),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .op_func    (op_func),
      .op_data    (op_data),
      .alu_data   (alu_data),
      .alu_func   (alu_func),
      .alu_result (acc),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .ops_issued (ops_issued),
      .seq_state  (seq_state)
   );

   // Accumulator ALU: A = Data, B = accumulator low nibble, Function[2] ignored.
   function automatic logic [7:0] alu_next(input logic [2:0] f, input logic [3:0] a,
                                           input logic [3:0] b);
      case (f[1:0])
         2'b00:   return {3'b000, {1'b0, a} + {1'b0, b}};
         2'b01:   return {7'd0, |{a, b}};
         2'b10:   return {7'd0, &{a, b}};
         default: return {a, b};
      endcase
   endfunction

   always_ff @(posedge Clock or negedge Reset_b) begin
      if (!Reset_b) acc <= 8'h00;
      else          acc <= alu_next(alu_func, alu_data, acc[3:0]);
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: every accepted result must match the next expected value.
   always @(negedge Clock) begin
      if (Reset_b && res_valid && res_ready) begin
         check("result_pending", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) check("res_data", res_data, exp_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_cycles(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic set_ready(input logic v);
      @(posedge Clock);
      #1 res_ready = v;
   endtask

   task automatic push_op(input logic [2:0] f, input logic [3:0] d, input logic [7:0] exp);
      int n = 0;
      @(negedge Clock);
      op_valid = 1'b1;
      op_func  = f;
      op_data  = d;
      while (!op_ready && n < BUDGET) begin
         @(negedge Clock);
         n++;
      end
      if (n >= BUDGET) check("push_timeout", op_ready, 1);
      @(posedge Clock);
      #1 op_valid = 1'b0;
      exp_q.push_back(exp);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < BUDGET) begin
         @(posedge Clock);
         #1 n++;
      end
      check(tag, exp_q.size(), 0);
      wait_cycles(2);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      Reset_b   = 1'b0;
      op_valid  = 1'b0;
      op_func   = 3'b000;
      op_data   = 4'h0;
      res_ready = 1'b1;
      wait_cycles(3);
      Reset_b = 1'b1;
      wait_cycles(1);

      check("rst_op_ready", op_ready, 1);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 8'h00);
      check("rst_alu_func", alu_func, 3'b000);
      check("rst_alu_data", alu_data, 4'h0);
      check("rst_ops_issued", ops_issued, 0);
      check("rst_state", seq_state, IDLE);

      // ADD 3 then ADD 5 from acc=0x00; trace first-op latency.
      push_op(3'b000, 4'h3, 8'h03);
      wait_cycles(1);
      check("issue_data", alu_data, 4'h3);
      check("issue_state", seq_state, ISSUE);
      wait_cycles(1);
      check("nop_after_issue", alu_data, 4'h0);
      check("not_yet_valid", res_valid, 0);
      wait_cycles(1);
      check("first_latency", res_valid, 1);
      check("first_res_data", res_data, 8'h03);
      push_op(3'b000, 4'h5, 8'h08);
      wait_drain("drain_add");
      check("ops_after_add", ops_issued, 2);

      // CONCAT A from 0x08, then the no-op restores 0x08; OR_ANY 0 gives 1.
      push_op(3'b011, 4'hA, 8'hA8);
      begin
         int n = 0;
         while (!res_valid && n < 20) begin
            wait_cycles(1);
            n++;
         end
      end
      check("concat_valid", res_valid, 1);
      check("nop_preserve", acc, 8'h08);
      push_op(3'b001, 4'h0, 8'h01);
      wait_drain("drain_concat");

      // Stalled consumer: 1 op in flight, 8 queued, then the FIFO is full.
      set_ready(1'b0);
      for (int k = 0; k < 9; k++) push_op(3'b011, 4'(k), {4'(k), 4'h1});
      check("stall_full", op_ready, 0);
      check("stall_valid", res_valid, 1);
      check("stall_hold0", res_data, 8'h01);
      wait_cycles(5);
      check("stall_hold1", res_data, 8'h01);
      check("stall_state", seq_state, RESULT);
      set_ready(1'b1);
      push_op(3'b011, 4'h9, 8'h91);
      wait_drain("drain_stall");
      check("ops_after_stall", ops_issued, 14);

      // Push at full alongside a result accept is dropped; pointers wrap.
      set_ready(1'b0);
      for (int k = 1; k < 10; k++) push_op(3'b011, 4'(k), {4'(k), 4'h1});
      check("full_again", op_ready, 0);
      @(posedge Clock);
      #1;
      res_ready = 1'b1;
      op_valid  = 1'b1;
      op_func   = 3'b011;
      op_data   = 4'hF;
      wait_cycles(1);
      check("accept_clears", res_valid, 0);
      check("full_in_idle", op_ready, 0);
      check("idle_after_accept", seq_state, IDLE);
      wait_cycles(1);
      op_valid = 1'b0;
      check("ready_after_pop", op_ready, 1);
      push_op(3'b000, 4'h2, 8'h03);
      push_op(3'b000, 4'h4, 8'h07);
      push_op(3'b011, 4'hC, 8'hC7);
      wait_drain("drain_wrap");
      check("ops_after_wrap", ops_issued, 26);

      // Reset in the middle of CAPTURE with three ops still queued.
      set_ready(1'b0);
      push_op(3'b000, 4'h1, 8'h08);
      for (int k = 1; k < 5; k++) push_op(3'b011, 4'(k), 8'h00);
      set_ready(1'b1);
      wait_cycles(3);
      check("pre_reset_state", seq_state, CAPTURE);
      Reset_b = 1'b0;
      #1;
      check("mid_rst_res_valid", res_valid, 0);
      check("mid_rst_op_ready", op_ready, 1);
      check("mid_rst_alu_func", alu_func, 3'b000);
      check("mid_rst_ops_issued", ops_issued, 0);
      check("mid_rst_state", seq_state, IDLE);
      exp_q.delete();
      wait_cycles(2);
      Reset_b = 1'b1;
      wait_cycles(20);
      check("post_rst_res_valid", res_valid, 0);
      check("post_rst_ops_issued", ops_issued, 0);
      check("post_rst_op_ready", op_ready, 1);
      check("post_rst_acc", acc, 8'h00);

      // Counter wrap: 255 ops, then the 256th returns ops_issued to 0.
      for (int i = 0; i < 255; i++) push_op(3'b011, 4'(i), {4'(i), 4'h0});
      wait_drain("drain_255");
      check("ops_255", ops_issued, 255);
      push_op(3'b011, 4'hF, 8'hF0);
      wait_drain("drain_256");
      check("ops_wrap", ops_issued, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
